// File: rtl/fifo_pkg.sv
// Shared helpers for the flexible FIFO: width derivation, wrapping pointer
// increment and parameter legality.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic bit params_ok(input int depth, input int ae, input int af, input int fwft);
    return (depth >= 2) && (ae >= 0) && (ae < af) && (af <= depth) && (fwft inside {0, 1});
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; count/pointers alone decide what is valid,
  // and a reset here would prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO, any DEPTH >= 2, standard or first-word-fall-through read,
// with count, threshold flags, sticky error flags and synchronous flush.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      w_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      r_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if (!params_ok(DEPTH, AE_THRESH, AF_THRESH, FWFT)) begin : g_bad_params
    $error("fifo_flex: illegal DEPTH/AE_THRESH/AF_THRESH/FWFT combination");
  end

  logic [PTR_W-1:0]      w_ptr, r_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ok, rd_ok;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO still takes a write when the head word leaves in the same cycle.
  assign rd_ok = r_en & ~empty & ~flush;
  assign wr_ok = w_en & (~full | rd_ok) & ~flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (w_ptr),
    .wdata (data_in),
    .raddr (r_ptr),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= PTR_W'(ptr_inc(32'(w_ptr), DEPTH));
      if (rd_ok) r_ptr <= PTR_W'(ptr_inc(32'(r_ptr), DEPTH));
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      if (w_en && !wr_ok) overflow  <= 1'b1;
      if (r_en && !rd_ok) underflow <= 1'b1;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) dout_q <= rd_data;
      end
    end

    assign data_out = dout_q;
    assign valid    = valid_q;
  end else begin : g_fwft
    assign data_out = rd_data;
    assign valid    = ~empty;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: standard-mode DEPTH=5 instance checked through a read
// scoreboard plus flag checks, and an FWFT DEPTH=4 instance with direct checks.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Standard-mode instance, DEPTH=5 (AF=4, AE=1)
  logic       flush = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in),
    .r_en(r_en), .data_out(data_out), .valid(valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // FWFT instance, DEPTH=4
  logic       f_flush = 1'b0, f_w_en = 1'b0, f_r_en = 1'b0;
  logic [7:0] f_data_in = '0, f_data_out;
  logic       f_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [2:0] f_count;

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .flush(f_flush), .w_en(f_w_en), .data_in(f_data_in),
    .r_en(f_r_en), .data_out(f_data_out), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    w_en = 1'b1; data_in = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] exp);
    r_en = 1'b1;
    sb.push_back(exp);
    tick();
    r_en = 1'b0;
  endtask

  // Monitor: every valid standard-mode output must match the next expected word.
  always @(negedge clk) begin
    if (!rst && valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: valid with data 0x%0h, expected no output", data_out);
      end else begin
        automatic logic [7:0] exp = sb.pop_front();
        if (data_out !== exp) begin
          n_err++;
          $display("FAIL sb_data: got 0x%0h, expected 0x%0h", data_out, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base;

    // Reset state
    tick(); tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Fill 0x11..0x15, thresholds along the way
    for (int i = 0; i < 5; i++) begin
      wr(8'h11 + 8'(i));
      if (i == 0) check("ae_at1", almost_empty, 1);
      if (i == 1) check("ae_at2", almost_empty, 0);
      if (i == 3) begin
        check("af_at4", almost_full, 1);
        check("full_at4", full, 0);
      end
    end
    check("fill_full", full, 1);
    check("fill_count", count, 5);

    // Overflow write is dropped
    wr(8'h16);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 5);

    for (int i = 0; i < 5; i++) rd(8'h11 + 8'(i));
    check("drain_empty", empty, 1);
    tick();
    check("hold_valid", valid, 0);
    check("hold_dout", data_out, 8'h15);

    // Wrap: 4 rounds of 3 writes / 3 reads
    for (int r = 0; r < 4; r++) begin
      base = 8'h40 + 8'(r * 16);
      for (int i = 0; i < 3; i++) wr(base + 8'(i));
      for (int i = 0; i < 3; i++) rd(base + 8'(i));
    end
    check("wrap_empty", empty, 1);

    // Flush with count=3 and overflow still sticky
    for (int i = 0; i < 3; i++) wr(8'h60 + 8'(i));
    check("pre_flush_count", count, 3);
    check("pre_flush_ovf", overflow, 1);
    flush = 1'b1; w_en = 1'b1; r_en = 1'b1;
    tick();
    flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_ovf", overflow, 0);
    check("flush_udf", underflow, 0);
    check("flush_valid", valid, 0);

    // Full plus simultaneous write/read
    for (int i = 0; i < 5; i++) wr(8'h21 + 8'(i));
    w_en = 1'b1; data_in = 8'hAA; r_en = 1'b1; sb.push_back(8'h21);
    tick();
    w_en = 1'b0; r_en = 1'b0;
    check("fullrw_count", count, 5);
    check("fullrw_ovf", overflow, 0);
    for (int i = 1; i < 5; i++) rd(8'h21 + 8'(i));
    rd(8'hAA);
    check("fullrw_empty", empty, 1);

    // Empty plus simultaneous write/read
    w_en = 1'b1; data_in = 8'h3C; r_en = 1'b1;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    check("emptyrw_udf", underflow, 1);
    check("emptyrw_count", count, 1);
    check("emptyrw_ovf", overflow, 0);
    rd(8'h3C);
    check("emptyrw_drain", empty, 1);

    // FWFT: word visible one cycle after write without r_en
    f_w_en = 1'b1; f_data_in = 8'h7E;
    tick();
    f_w_en = 1'b0;
    check("fwft_dout", f_data_out, 8'h7E);
    check("fwft_valid", f_valid, 1);
    tick();
    check("fwft_hold", f_data_out, 8'h7E);
    f_w_en = 1'b1; f_data_in = 8'h5A;
    tick();
    f_w_en = 1'b0; f_r_en = 1'b1;
    tick();
    check("fwft_next", f_data_out, 8'h5A);
    check("fwft_count1", f_count, 1);
    tick();
    f_r_en = 1'b0;
    check("fwft_empty", f_empty, 1);
    check("fwft_valid0", f_valid, 0);

    // Reset mid-burst
    w_en = 1'b1; data_in = 8'h91;
    tick();
    data_in = 8'h92; r_en = 1'b1; sb.push_back(8'h91);
    tick();
    data_in = 8'h93;
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_dout", data_out, 0);
    check("mid_rst_udf", underflow, 0);
    check("mid_rst_af", almost_full, 0);
    w_en = 1'b0; r_en = 1'b0;
    tick();
    @(negedge clk); rst = 1'b0;
    tick(); tick();

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
